// File: rtl/johnson_decoder.sv
// Johnson-code monitor with a Wishbone classic slave.
// jc_in is synchronised, decoded to a state index with a legality flag, and
// tracked in stage 4: legal single steps count, illegal words and skipped
// states raise saturating error counters with sticky flags and an interrupt.
module johnson_decoder #(
    parameter int BITS  = 32,
    parameter int IDX_W = 6
) (
    input  logic             wb_clk_i,
    input  logic             wb_rst_ni,
    input  logic             wbs_cyc_i,
    input  logic             wbs_stb_i,
    input  logic             wbs_we_i,
    input  logic [3:0]       wbs_sel_i,
    input  logic [31:0]      wbs_adr_i,
    input  logic [31:0]      wbs_dat_i,
    output logic             wbs_ack_o,
    output logic [31:0]      wbs_dat_o,
    input  logic [BITS-1:0]  jc_in,
    output logic             irq_o
);

    localparam int NST = 2 * BITS;

    // Stage-4 tracking state and counters
    typedef struct packed {
        logic [31:0]      step;
        logic [15:0]      eill;
        logic [15:0]      eskip;
        logic             sti;
        logic             sts;
        logic             primed;
        logic [IDX_W-1:0] prev;
    } st4_t;

    // Software control bits held across cycles (clear is a pulse, not stored)
    typedef struct packed {
        logic irq_en;
        logic en;
    } ctrl_t;

    logic [BITS-1:0]  s1, s2;
    logic [IDX_W-1:0] pop_c, idx_c, idx3, succ_c;
    logic [BITS-1:0]  enc_c;
    logic             legal_c, leg3;
    int               k_c;

    st4_t  st_q, st_n;
    ctrl_t ctrl_q, ctrl_n;
    logic  irq_q, irq_n;
    logic  ack_q;
    logic [31:0] dat_q, rdata_c;

    logic       req, wr, ctrl_wr, stat_wr, clr;
    logic [1:0] rsel;
    logic       ev_ill, ev_skip;

    // Address bits outside [3:2], upper byte enables and upper data bits carry no meaning here
    logic unused_bits;
    assign unused_bits = ^{wbs_adr_i[31:4], wbs_adr_i[1:0], wbs_sel_i[3:1], wbs_dat_i[31:3]};

    // Two-flop synchroniser for the asynchronous code word
    always_ff @(posedge wb_clk_i) begin
        if (!wb_rst_ni) begin
            s1 <= '0;
            s2 <= '0;
        end else begin
            s1 <= jc_in;
            s2 <= s1;
        end
    end

    // Index from popcount, then rebuild the canonical word to judge legality
    always_comb begin
        pop_c = '0;
        for (int i = 0; i < BITS; i++) pop_c = pop_c + IDX_W'(s2[i]);
        // Modular subtract gives 2*BITS - popcount when the MSB is set
        idx_c = s2[BITS-1] ? (IDX_W'(NST) - pop_c) : pop_c;
        k_c   = int'(idx_c);
        enc_c = '0;
        for (int i = 0; i < BITS; i++)
            enc_c[i] = (k_c <= BITS) ? (i < k_c) : (i >= k_c - BITS);
        legal_c = (s2 == enc_c);
    end

    // Stage 3 register: decoded index and legality
    always_ff @(posedge wb_clk_i) begin
        if (!wb_rst_ni) begin
            idx3 <= '0;
            leg3 <= 1'b0;
        end else begin
            idx3 <= idx_c;
            leg3 <= legal_c;
        end
    end

    // Bus request decode: a request is accepted on the edge where ack rises
    always_comb begin
        req     = wbs_cyc_i & wbs_stb_i & ~ack_q;
        wr      = req & wbs_we_i;
        rsel    = wbs_adr_i[3:2];
        ctrl_wr = wr && (rsel == 2'd0) && wbs_sel_i[0];
        stat_wr = wr && (rsel == 2'd1) && wbs_sel_i[0];
        clr     = ctrl_wr && wbs_dat_i[2];
    end

    // Successor index, wrapping at 2*BITS even when that is not a power of two
    always_comb begin
        succ_c = (st_q.prev == IDX_W'(NST - 1)) ? '0 : st_q.prev + 1'b1;
    end

    // Stage 4 next state: step/skip/illegal tracking, sticky flags, clear, control
    always_comb begin
        st_n    = st_q;
        ctrl_n  = ctrl_q;
        ev_ill  = 1'b0;
        ev_skip = 1'b0;
        if (ctrl_q.en) begin
            if (!leg3) begin
                ev_ill      = 1'b1;
                st_n.primed = 1'b0;
            end else if (!st_q.primed) begin
                st_n.prev   = idx3;
                st_n.primed = 1'b1;
            end else if (idx3 == st_q.prev) begin
                st_n.prev = st_q.prev;
            end else if (idx3 == succ_c) begin
                st_n.step = st_q.step + 32'd1;
                st_n.prev = idx3;
            end else begin
                ev_skip   = 1'b1;
                st_n.prev = idx3;
            end
        end else begin
            st_n.primed = 1'b0;
        end
        if (ev_ill && st_q.eill != 16'hFFFF)   st_n.eill  = st_q.eill + 16'd1;
        if (ev_skip && st_q.eskip != 16'hFFFF) st_n.eskip = st_q.eskip + 16'd1;
        // W1C first, then a same-cycle event re-sets the flag
        st_n.sti = (st_q.sti & ~(stat_wr & wbs_dat_i[0])) | ev_ill;
        st_n.sts = (st_q.sts & ~(stat_wr & wbs_dat_i[1])) | ev_skip;
        if (ctrl_wr) begin
            ctrl_n.en     = wbs_dat_i[0];
            ctrl_n.irq_en = wbs_dat_i[1];
        end
        // Clear discards this cycle's events; prev is left as it was
        if (clr) begin
            st_n.step   = '0;
            st_n.eill   = '0;
            st_n.eskip  = '0;
            st_n.sti    = 1'b0;
            st_n.sts    = 1'b0;
            st_n.primed = 1'b0;
            st_n.prev   = st_q.prev;
        end
        irq_n = ctrl_n.irq_en & (st_n.sti | st_n.sts);
    end

    // Read mux over the four registers; unused bits return 0
    always_comb begin
        rdata_c = '0;
        case (rsel)
            2'd0: rdata_c = {29'd0, 1'b0, ctrl_q.irq_en, ctrl_q.en};
            2'd1: begin
                rdata_c[0]          = st_q.sti;
                rdata_c[1]          = st_q.sts;
                rdata_c[2]          = st_q.primed;
                rdata_c[8 +: IDX_W] = st_q.prev;
            end
            2'd2: rdata_c = st_q.step;
            default: rdata_c = {st_q.eskip, st_q.eill};
        endcase
    end

    // Stage 4, control and interrupt registers
    always_ff @(posedge wb_clk_i) begin
        if (!wb_rst_ni) begin
            st_q   <= '0;
            ctrl_q <= '0;
            irq_q  <= 1'b0;
        end else begin
            st_q   <= st_n;
            ctrl_q <= ctrl_n;
            irq_q  <= irq_n;
        end
    end

    // Single-cycle ack with read data valid only alongside it
    always_ff @(posedge wb_clk_i) begin
        if (!wb_rst_ni) begin
            ack_q <= 1'b0;
            dat_q <= '0;
        end else begin
            ack_q <= req;
            dat_q <= req ? rdata_c : 32'd0;
        end
    end

    assign wbs_ack_o = ack_q;
    assign wbs_dat_o = dat_q;
    assign irq_o     = irq_q;

endmodule

// File: tb/tb_johnson_decoder.sv
// Bench for johnson_decoder: cycle-level reference model built from the code
// definition (table search over all 2*BITS canonical words) plus directed
// scenarios and a randomized phase.
module tb_johnson_decoder;

    localparam int BITS  = 32;
    localparam int IDX_W = 6;
    localparam int NST   = 2 * BITS;

    logic            clk = 1'b0;
    logic            rst_n, cyc, stb, we, ack, irq;
    logic [3:0]      sel;
    logic [31:0]     adr, wdat, rdat;
    logic [BITS-1:0] jc;

    int n_cmp = 0;
    int n_err = 0;

    // reference model state
    logic [BITS-1:0] m_s1, m_s2;
    int              m_k3;
    bit              m_en, m_ie, m_primed, m_sti, m_sts, m_ack, m_irq;
    int              m_prev;
    logic [31:0]     m_step, m_dat;
    int              m_eill, m_eskip;

    always #5 clk = ~clk;

    johnson_decoder #(.BITS(BITS), .IDX_W(IDX_W)) dut (
        .wb_clk_i(clk), .wb_rst_ni(rst_n),
        .wbs_cyc_i(cyc), .wbs_stb_i(stb), .wbs_we_i(we),
        .wbs_sel_i(sel), .wbs_adr_i(adr), .wbs_dat_i(wdat),
        .wbs_ack_o(ack), .wbs_dat_o(rdat),
        .jc_in(jc), .irq_o(irq)
    );

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s got=%h exp=%h t=%0t", tag, got, exp, $time);
        end
    endtask

    // canonical word of state k
    function automatic logic [BITS-1:0] enc(input int k);
        longint unsigned full, v;
        full = (64'd1 << BITS) - 1;
        if (k <= BITS) v = (64'd1 << k) - 1;
        else           v = full & ~((64'd1 << (k - BITS)) - 1);
        return v[BITS-1:0];
    endfunction

    // state index of a word, -1 if it is no canonical word
    function automatic int ref_idx(input logic [BITS-1:0] v);
        for (int k = 0; k < NST; k++) if (enc(k) == v) return k;
        return -1;
    endfunction

    function automatic logic [31:0] m_read(input logic [1:0] a);
        case (a)
            2'd0: return {30'd0, m_ie, m_en};
            2'd1: return {16'd0, 2'b00, 6'(m_prev), 5'd0, m_primed, m_sts, m_sti};
            2'd2: return m_step;
            default: return {16'(m_eskip), 16'(m_eill)};
        endcase
    endfunction

    // advance the model by one rising edge using the inputs present at that edge
    task automatic model_step();
        bit req, wr, ev_i, ev_s, n_en, n_ie, n_pr, n_si, n_ss;
        int n_prev, n_ei, n_es, n_k3;
        logic [31:0] n_step, rd;
        logic [1:0] a;
        a   = adr[3:2];
        req = cyc && stb && !m_ack;
        wr  = req && we;
        rd  = m_read(a);
        if (!rst_n) begin
            m_s1 = '0; m_s2 = '0; m_k3 = -1;
            m_en = 0; m_ie = 0; m_primed = 0; m_sti = 0; m_sts = 0;
            m_prev = 0; m_step = '0; m_eill = 0; m_eskip = 0;
            m_ack = 0; m_dat = '0; m_irq = 0;
            return;
        end
        n_en = m_en; n_ie = m_ie; n_pr = m_primed; n_prev = m_prev;
        n_step = m_step; n_ei = m_eill; n_es = m_eskip; ev_i = 0; ev_s = 0;
        if (m_en) begin
            if (m_k3 < 0) begin
                ev_i = 1; n_pr = 0;
            end else if (!m_primed) begin
                n_prev = m_k3; n_pr = 1;
            end else if (m_k3 == (m_prev + 1) % NST) begin
                n_step = m_step + 1; n_prev = m_k3;
            end else if (m_k3 != m_prev) begin
                ev_s = 1; n_prev = m_k3;
            end
        end else n_pr = 0;
        if (ev_i && n_ei < 65535) n_ei++;
        if (ev_s && n_es < 65535) n_es++;
        n_si = m_sti; n_ss = m_sts;
        if (wr && a == 1 && sel[0] && wdat[0]) n_si = 0;
        if (wr && a == 1 && sel[0] && wdat[1]) n_ss = 0;
        if (ev_i) n_si = 1;
        if (ev_s) n_ss = 1;
        if (wr && a == 0 && sel[0]) begin
            n_en = wdat[0]; n_ie = wdat[1];
            if (wdat[2]) begin
                n_step = '0; n_ei = 0; n_es = 0; n_si = 0; n_ss = 0; n_pr = 0;
                n_prev = m_prev;
            end
        end
        n_k3 = ref_idx(m_s2);
        m_s2 = m_s1; m_s1 = jc; m_k3 = n_k3;
        m_en = n_en; m_ie = n_ie; m_primed = n_pr; m_prev = n_prev;
        m_step = n_step; m_eill = n_ei; m_eskip = n_es; m_sti = n_si; m_sts = n_ss;
        m_irq = n_ie && (n_si || n_ss);
        m_ack = req;
        m_dat = req ? rd : 32'd0;
    endtask

    // one clock: model follows the edge, outputs compared on the falling edge
    task automatic tick();
        @(posedge clk);
        model_step();
        @(negedge clk);
        chk("ack", {31'd0, ack}, {31'd0, m_ack});
        chk("dat_o", rdat, m_dat);
        chk("irq", {31'd0, irq}, {31'd0, m_irq});
    endtask

    task automatic wb(input bit w, input logic [31:0] a, input logic [31:0] d,
                      input logic [3:0] s, output logic [31:0] r);
        int n;
        cyc = 1; stb = 1; we = w; adr = a; wdat = d; sel = s;
        n = 0;
        do begin tick(); n++; end while (!ack && n < 4);
        chk("ack_seen", {31'd0, ack}, 32'd1);
        r = rdat;
        cyc = 0; stb = 0; we = 0;
        tick();
    endtask

    task automatic wr(input logic [31:0] a, input logic [31:0] d);
        logic [31:0] r;
        wb(1'b1, a, d, 4'hF, r);
    endtask

    task automatic rd(input logic [31:0] a, output logic [31:0] r);
        wb(1'b0, a, 32'd0, 4'hF, r);
    endtask

    task automatic hold(input logic [BITS-1:0] v, input int n);
        jc = v;
        repeat (n) tick();
    endtask

    initial begin
        #5_000_000;
        $display("FAIL watchdog expired");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [31:0] r;
        int k, sel_r;
        rst_n = 0; cyc = 0; stb = 0; we = 0; sel = '0; adr = '0; wdat = '0;
        jc = 32'h0000_00FF;
        @(negedge clk);
        repeat (3) tick();
        rst_n = 1;
        jc = '0;
        tick();
        // reset values
        for (int a = 0; a < 4; a++) begin
            rd(32'(a * 4), r);
            chk("rst_reg", r, 32'd0);
        end

        // full cycle through all states and back to 0
        wr(32'h0, 32'h1);
        hold('0, 4);
        for (int i = 1; i < NST; i++) hold(enc(i), 3);
        hold('0, 6);
        rd(32'h8, r);  chk("walk_step", r, 32'd64);
        rd(32'hC, r);  chk("walk_err", r, 32'd0);
        rd(32'h4, r);  chk("walk_prev", (r >> 8) & 32'h3F, 32'd0);
        chk("walk_primed", (r >> 2) & 32'h1, 32'd1);

        // skip from idx 5 to idx 7
        hold(32'h1F, 6);
        wr(32'h0, 32'h7);
        hold(32'h1F, 6);
        hold(32'h7F, 6);
        rd(32'hC, r);  chk("skip_err", r, 32'h0001_0000);
        rd(32'h4, r);  chk("skip_status", r & 32'h3F03, 32'h0702);
        chk("skip_irq", {31'd0, irq}, 32'd1);

        // single illegal word, then re-prime at idx 3 without a skip
        wr(32'h0, 32'h7);
        chk("clr_irq", {31'd0, irq}, 32'd0);
        hold(32'h5, 1);
        hold(32'h7, 6);
        rd(32'hC, r);  chk("ill_err", r, 32'h0000_0001);
        rd(32'h4, r);  chk("ill_status", r, 32'h0000_0305);

        // saturation of err_illegal
        wr(32'h0, 32'h7);
        hold(32'h5, 65540);
        hold(32'h7, 6);
        rd(32'hC, r);  chk("sat_err", r, 32'h0000_FFFF);
        wr(32'h0, 32'h7);
        rd(32'h8, r);  chk("clr_step", r, 32'd0);
        rd(32'hC, r);  chk("clr_err", r, 32'd0);
        chk("clr_irq2", {31'd0, irq}, 32'd0);

        // W1C on sticky_skip in the same edge as a new skip
        hold(32'hF, 6);
        jc = 32'hFF;
        repeat (3) tick();
        cyc = 1; stb = 1; we = 1; adr = 32'h4; wdat = 32'h2; sel = 4'h1;
        tick();
        chk("w1c_ack", {31'd0, ack}, 32'd1);
        cyc = 0; stb = 0; we = 0;
        tick();
        rd(32'h4, r);  chk("w1c_keep", r & 32'h2, 32'h2);
        wr(32'h4, 32'h2);
        rd(32'h4, r);  chk("w1c_clear", r & 32'h2, 32'h0);
        // step-count read with cyc held past ack
        cyc = 1; stb = 1; we = 0; adr = 32'h8;
        tick();
        chk("rd8_ack", {31'd0, ack}, 32'd1);
        chk("rd8_dat", rdat, m_step);
        tick();
        chk("rd8_ack_drop", {31'd0, ack}, 32'd0);
        cyc = 0; stb = 0;
        tick();

        // reset during a CTRL write
        cyc = 1; stb = 1; we = 1; adr = 32'h0; wdat = 32'h1; sel = 4'hF; rst_n = 0;
        tick();
        chk("rst_wr_ack", {31'd0, ack}, 32'd0);
        cyc = 0; stb = 0; we = 0;
        tick();
        rst_n = 1;
        tick();
        rd(32'h0, r);  chk("rst_ctrl", r, 32'd0);
        hold('0, 6);
        for (int i = 1; i < 6; i++) hold(enc(i), 3);
        rd(32'h8, r);  chk("rst_nocount", r, 32'd0);

        // randomized phase
        wr(32'h0, 32'h3);
        k = 5;
        for (int it = 0; it < 1500; it++) begin
            sel_r = $urandom_range(0, 99);
            if (sel_r < 60) begin
                k = (k + 1) % NST;
                hold(enc(k), $urandom_range(1, 3));
            end else if (sel_r < 68) begin
                k = $urandom_range(0, NST - 1);
                hold(enc(k), $urandom_range(1, 3));
            end else if (sel_r < 73) begin
                hold($urandom, $urandom_range(1, 2));
                hold(enc(k), 1);
            end else if (sel_r < 88) begin
                rd($urandom, r);
            end else if (sel_r < 96) begin
                wb(1'b1, $urandom, $urandom | 32'h1, 4'($urandom), r);
            end else begin
                // strobe without cycle (or vice versa) never completes
                cyc = sel_r[0]; stb = ~sel_r[0]; we = 1; adr = 32'h0; wdat = 32'h4; sel = 4'hF;
                repeat (2) tick();
                cyc = 0; stb = 0; we = 0;
                tick();
            end
        end
        rd(32'h8, r);  chk("rnd_step", r, m_step);
        rd(32'hC, r);  chk("rnd_err", r, {16'(m_eskip), 16'(m_eill)});

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule

// File: doc/johnson_decoder.md
JOHNSON_DECODER -- requirements
Module: johnson_decoder

Interface
REQ-001 Parameter BITS, default 32, width of the monitored Johnson code word (>=2); the code has 2*BITS states.
REQ-002 Parameter IDX_W, default 6, index width, equal to ceil(log2(2*BITS)).
REQ-003 wb_clk_i  input  1  single clock; all state is updated on its rising edge.
REQ-004 wb_rst_ni  input  1  reset, synchronous, active-low.
REQ-005 wbs_cyc_i, wbs_stb_i, wbs_we_i  input  1 each  Wishbone classic slave controls.
REQ-006 wbs_sel_i  input  4  byte enables; writes SHALL update only the selected bytes.
REQ-007 wbs_adr_i  input  32  address; only bits [3:2] SHALL be decoded.
REQ-008 wbs_dat_i  input  32  write data.
REQ-009 wbs_ack_o  output  1  transfer acknowledge.
REQ-010 wbs_dat_o  output  32  read data.
REQ-011 jc_in  input  BITS  asynchronous Johnson-coded word from a counter.
REQ-012 irq_o  output  1  level interrupt.

Function
REQ-013 Code definition: state k SHALL be encoded as (2^k)-1 for 0<=k<=BITS; for BITS<k<2*BITS, ones occupy bits [BITS-1 : k-BITS] only. The successor of k is (k+1) mod 2*BITS, i.e. shift left, inserting ~MSB at bit 0.
REQ-014 jc_in SHALL pass through a 2-flop synchronizer (stages s1, s2) before any use.
REQ-015 Stage 3 SHALL register idx and legal from s2: MSB=0 -> idx=popcount; MSB=1 -> idx=2*BITS-popcount; legal=1 only if s2 equals the REQ-013 encoding of idx.
REQ-016 Stage 4, only when CTRL.enable=1: illegal -> err_illegal+1, primed cleared; legal and !primed -> prev=idx, primed set, no check; legal and idx==prev -> no count; legal and idx==prev+1 mod 2*BITS (including 2*BITS-1 -> 0) -> step_cnt+1, prev=idx; any other legal idx -> err_skip+1, prev=idx.
REQ-017 Counters update exactly 4 rising edges after a jc_in change held stable.
REQ-018 step_cnt is 32 bits and SHALL wrap; err_illegal and err_skip are 16 bits each and SHALL saturate at 0xFFFF.
REQ-019 CTRL.enable=0: stage 4 SHALL hold all counters, and primed SHALL be cleared.
REQ-020 Registers (adr[3:2]): 0 CTRL RW {bit0 enable, bit1 irq_en, bit2 clear (write-only, reads 0)}; 1 STATUS {bit0 sticky_illegal W1C, bit1 sticky_skip W1C, bit2 primed RO, bits[8+IDX_W-1:8] prev RO}; 2 STEP_CNT RO; 3 ERR_CNT RO {[31:16] err_skip, [15:0] err_illegal}.
REQ-021 Writing clear=1 SHALL zero all three counters and both sticky bits and clear primed in the same edge; stage-4 events in that cycle SHALL be discarded.
REQ-022 Sticky bits SHALL set on the respective error event; when a W1C write coincides with a new event, the bit SHALL remain set.
REQ-023 irq_o SHALL equal irq_en AND (sticky_illegal OR sticky_skip), driven from a register.
REQ-024 Handshake: with cyc&stb high and ack low, ack SHALL assert on the next edge for exactly one cycle; the write takes effect on that edge; wbs_dat_o is valid while ack is high and 0 otherwise.
REQ-025 Writes to RO registers SHALL be acknowledged and ignored; unused read bits SHALL return 0.
REQ-026 Dropping cyc or stb before ack SHALL abort the transfer with no side effect.

Reset
REQ-027 While wb_rst_ni=0 at an edge: s1, s2, stage-3 and stage-4 state, counters, sticky bits, primed, prev, CTRL SHALL become 0; wbs_ack_o=0, wbs_dat_o=0, irq_o=0.
REQ-028 Reset asserted mid-transfer SHALL drop ack and discard the write; reset SHALL override clear and all events.

Verification
REQ-029 Enable, drive 0x0, 0x1, 0x3 ... through all 64 states and back to 0x0, each held 3 cycles -> STEP_CNT=64, ERR_CNT=0, STATUS.prev=0.
REQ-030 Primed at idx 5 (0x1F), drive 0x7F (idx 7) -> err_skip=1, sticky_skip=1, irq_o=1 if irq_en.
REQ-031 Drive 0x00000005 -> err_illegal=1, primed=0; then 0x7 -> no skip counted, prev=3.
REQ-032 Force 0xFFFF illegal events -> err_illegal stays 0xFFFF; write CTRL.clear -> all counters 0, irq_o=0.
REQ-033 W1C sticky_skip coincident with a new skip event -> sticky_skip reads 1; read of 0x8 returns the step count with ack high for exactly 1 cycle.
REQ-034 Assert wb_rst_ni=0 during a CTRL write -> no ack, CTRL=0 after release; jc_in stepping then produces no counts.
